// File: rtl/mem_pkg.sv
// Shared types for the mem_handle responder.
// Provides the data/address widths, the FSM state encoding, the operation
// kind, and the latched request record that travels from grant to response.
package mem_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  // Port index field is sized generously; the responder uses only the low bits.
  localparam int IDX_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic [ADDR_W-1:0]    ptr;
    logic [DATA_W-1:0]    wdata;
    op_e                  op;
    logic                 bad;
  } req_t;

endpackage

// File: rtl/mem_handle_responder_rr_arbiter.sv
// Combinational rotate-priority arbiter.
// Ports:
//   req          in  N   request vector
//   ptr_in       in  IW  index that has highest priority this cycle
//   grant_onehot out N   one-hot grant (zero when nothing requests)
//   grant_idx    out IW  binary index of the granted requester
//   any          out 1   at least one requester present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr_in,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] w_cand;

  // Walk the ports starting at ptr_in; the first requester found wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    w_cand       = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((int'(ptr_in) + k) % N);
      if (!any && req[w_cand]) begin
        any                  = 1'b1;
        grant_idx            = w_cand;
        grant_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_handle_responder.sv
// Memory-side responder for the mem_handle protocol.
// Serves N_PORTS initiators from one single-port word array, one access at a
// time, round-robin. Each access takes IDLE(grant) -> ACCESS -> RESP, with a
// one-cycle done pulse to the served port in RESP.
// Ports:
//   clk, rst_l        clock / asynchronous active-low reset
//   avail, r_en, w_en per-port request valid, read, write
//   ptr, data_store   per-port absolute word address and write data
//   done, data_load   per-port completion pulse and read data
//   region_begin/end  per-port constant window bounds
//   err               per-port sticky access error
//   busy              FSM not idle
module mem_handle_responder
  import mem_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int DEPTH     = 1024,
  parameter int REGION_SZ = 256
) (
  input  logic                             clk,
  input  logic                             rst_l,
  input  logic [N_PORTS-1:0]               avail,
  input  logic [N_PORTS-1:0]               r_en,
  input  logic [N_PORTS-1:0]               w_en,
  input  logic [N_PORTS-1:0][ADDR_W-1:0]   ptr,
  input  logic [N_PORTS-1:0][DATA_W-1:0]   data_store,
  output logic [N_PORTS-1:0]               done,
  output logic [N_PORTS-1:0][DATA_W-1:0]   data_load,
  output logic [N_PORTS-1:0][ADDR_W-1:0]   region_begin,
  output logic [N_PORTS-1:0][ADDR_W-1:0]   region_end,
  output logic [N_PORTS-1:0]               err,
  output logic                             busy
);

  localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                           r_state;
  state_e                           w_state_nxt;
  req_t                             r_req;
  logic [IDX_W-1:0]                 r_rr_ptr;
  logic [N_PORTS-1:0]               r_done;
  logic [N_PORTS-1:0]               r_err;
  logic [N_PORTS-1:0][DATA_W-1:0]   r_data_load;
  logic [DATA_W-1:0]                r_mem [DEPTH];

  logic [N_PORTS-1:0]               w_eligible;
  logic [N_PORTS-1:0]               w_grant_onehot;
  logic [IDX_W-1:0]                 w_grant_idx;
  logic                             w_any;
  logic [IDX_W-1:0]                 w_rr_next;
  logic [ADDR_W-1:0]                w_sel_ptr;
  logic                             w_bad;
  logic [IDX_W-1:0]                 w_req_idx;
  logic [MEM_AW-1:0]                w_mem_addr;
  logic                             w_unused;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_region
    assign region_begin[gi] = ADDR_W'(gi * REGION_SZ);
    assign region_end[gi]   = ADDR_W'((gi + 1) * REGION_SZ - 1);
  end

  // A port whose done is high is still showing the request just served.
  assign w_eligible = avail & (r_en | w_en) & ~r_done;

  rr_arbiter #(.N(N_PORTS), .IW(IDX_W)) u_arb (
    .req          (w_eligible),
    .ptr_in       (r_rr_ptr),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  assign w_rr_next = (w_grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;

  // Classify the request at grant time so ACCESS needs only the latched flag.
  assign w_sel_ptr = ptr[w_grant_idx];
  assign w_bad     = (r_en[w_grant_idx] & w_en[w_grant_idx])
                   | (w_sel_ptr < region_begin[w_grant_idx])
                   | (w_sel_ptr > region_end[w_grant_idx])
                   | (w_sel_ptr >= ADDR_W'(DEPTH));

  assign w_req_idx  = r_req.idx[IDX_W-1:0];
  assign w_mem_addr = r_req.ptr[MEM_AW-1:0];
  assign w_unused   = &{1'b0, r_req.idx, r_req.ptr, w_grant_onehot};

  // FSM state register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch: fields are captured only in the grant cycle.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_any) begin
      r_req.idx   <= IDX_MAX_W'(w_grant_idx);
      r_req.ptr   <= w_sel_ptr;
      r_req.wdata <= data_store[w_grant_idx];
      r_req.op    <= w_en[w_grant_idx] ? OP_WRITE : OP_READ;
      r_req.bad   <= w_bad;
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rr_ptr    <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_data_load <= '0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_any) r_rr_ptr <= w_rr_next;
        end
        ACCESS: begin
          r_done[w_req_idx] <= 1'b1;
          if (r_req.bad) begin
            r_err[w_req_idx]       <= 1'b1;
            r_data_load[w_req_idx] <= '0;
          end else if (r_req.op == OP_READ) begin
            r_data_load[w_req_idx] <= r_mem[w_mem_addr];
          end
        end
        default: ;
      endcase
    end
  end

  // Backing store: contents survive reset.
  always_ff @(posedge clk) begin
    if (r_state == ACCESS && r_req.op == OP_WRITE && !r_req.bad)
      r_mem[w_mem_addr] <= r_req.wdata;
  end

  assign done      = r_done;
  assign data_load = r_data_load;
  assign err       = r_err;
  assign busy      = (r_state != IDLE);

endmodule
